// File: rtl/bios_spi_rom_pkg.sv
// Shared constants, FSM state type and byte-order helper for the BIOS SPI ROM reader.
package bios_spi_rom_pkg;

    localparam logic [7:0] SPI_OP_READ = 8'h03;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DATA_BITS  = 32;
    localparam int FRAME_BITS = CMD_BITS + ADDR_BITS + DATA_BITS;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        STREAM,
        DESEL
    } state_t;

    // Flash returns bytes in address order; the first byte belongs in bits [7:0].
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCK divider, bit counter, MOSI shift-out, MISO shift-in, done pulse.
module spi_shift_engine
    import bios_spi_rom_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic [63:0] tx,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [6:0]  bits_left,
    output logic [31:0] rx
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [63:0]   sr_out;
    logic          load;
    logic          rise;
    logic          fall;

    assign load = start & ~busy;
    assign rise = busy & (div_cnt == '0) & ~sck;
    assign fall = busy & (div_cnt == '0) & sck;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            done      <= 1'b0;
            div_cnt   <= '0;
            bits_left <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                busy      <= 1'b1;
                sck       <= 1'b0;
                mosi      <= tx[63];
                div_cnt   <= DIV_LAST;
                bits_left <= len;
            end else if (busy) begin
                if (div_cnt != '0) begin
                    div_cnt <= div_cnt - DW'(1);
                end else begin
                    div_cnt <= DIV_LAST;
                    sck     <= ~sck;
                    if (sck) begin
                        bits_left <= bits_left - 7'd1;
                        if (bits_left == 7'd1) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            mosi <= 1'b0;
                        end else begin
                            mosi <= sr_out[63];
                        end
                    end
                end
            end
        end
    end

    // MOSI advances on the SCK fall; MISO is captured on the edge that raises SCK.
    always_ff @(posedge clk) begin
        if (load) begin
            sr_out <= {tx[62:0], 1'b0};
        end else if (fall) begin
            sr_out <= {sr_out[62:0], 1'b0};
        end
        if (rise) begin
            rx <= {rx[30:0], miso};
        end
    end

endmodule

// File: rtl/bios_spi_rom.sv
// BIOS ROM word reader: serves 32-bit ROM reads from SPI NOR flash with READ (0x03) frames.
// Optional macro BIOS_SPI_ROM_PREFETCH_EN streams the next sequential word after each frame.
module bios_spi_rom
    import bios_spi_rom_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int          CLK_DIV    = 1,
    parameter int          CS_HIGH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] rom_address,
    input  logic        rom_rd_enable,
    output logic [31:0] rom_rd_data,
    output logic        rom_rd_valid,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int CW = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
    localparam logic [CW-1:0] DESEL_LAST = CW'(CS_HIGH - 1);

    state_t        state;
    logic [13:0]   req_addr;
    logic [13:0]   buf_addr;
    logic [31:0]   buf_data;
    logic          buf_vld;
    logic [CW-1:0] desel_cnt;

    logic          miss;
    logic          frame_start;
    logic          stream_start;
    logic [23:0]   flash_addr;

    logic          eng_start;
    logic [6:0]    eng_len;
    logic [63:0]   eng_tx;
    logic          eng_busy;
    logic          eng_done;
    logic [6:0]    eng_bits_left;
    logic [31:0]   eng_rx;

    assign flash_addr   = FLASH_BASE + {8'h00, rom_address, 2'b00};
    assign rom_rd_data  = buf_data;
    assign rom_rd_valid = buf_vld & rom_rd_enable & (buf_addr == rom_address);
    assign miss         = rom_rd_enable & ~rom_rd_valid;
    assign frame_start  = (state == IDLE) & miss & ~eng_busy;

`ifdef BIOS_SPI_ROM_PREFETCH_EN
    logic [31:0] pf_data;
    logic [13:0] pf_tag;
    logic        pf_vld;
    logic        stream_miss;
    logic        stream_entry;
    logic        stream_hit;

    assign stream_entry = (state == DATA) & eng_done & (req_addr != 14'h3FFF);
    assign stream_hit   = (state == STREAM) & ~eng_done & pf_vld & miss & (rom_address == pf_tag);
    assign stream_start = stream_entry | (stream_hit & (pf_tag != 14'h3FFF));
`else
    assign stream_start = 1'b0;
`endif

    always_comb begin
        eng_start = frame_start | stream_start;
        eng_len   = 7'(FRAME_BITS);
        eng_tx    = {SPI_OP_READ, flash_addr, 32'h0};
        if (stream_start) begin
            eng_len = 7'(DATA_BITS);
            eng_tx  = '0;
        end
    end

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .start     (eng_start),
        .len       (eng_len),
        .tx        (eng_tx),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .busy      (eng_busy),
        .done      (eng_done),
        .bits_left (eng_bits_left),
        .rx        (eng_rx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            spi_cs_n  <= 1'b1;
            req_addr  <= '0;
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_vld   <= 1'b0;
            desel_cnt <= '0;
`ifdef BIOS_SPI_ROM_PREFETCH_EN
            pf_data     <= '0;
            pf_tag      <= '0;
            pf_vld      <= 1'b0;
            stream_miss <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= CMD;
                        spi_cs_n <= 1'b0;
                        req_addr <= rom_address;
                    end
                end
                CMD: begin
                    if (eng_bits_left == 7'(FRAME_BITS - CMD_BITS)) state <= ADDR;
                end
                ADDR: begin
                    if (eng_bits_left == 7'(DATA_BITS)) state <= DATA;
                end
                DATA: begin
                    // The frame is never aborted: the word always lands under the latched address.
                    if (eng_done) begin
                        buf_data <= byte_swap(eng_rx);
                        buf_addr <= req_addr;
                        buf_vld  <= 1'b1;
`ifdef BIOS_SPI_ROM_PREFETCH_EN
                        if (stream_entry) begin
                            state       <= STREAM;
                            pf_tag      <= req_addr + 14'd1;
                            pf_vld      <= 1'b0;
                            stream_miss <= 1'b0;
                        end else begin
                            state     <= DESEL;
                            spi_cs_n  <= 1'b1;
                            desel_cnt <= DESEL_LAST;
                        end
`else
                        state     <= DESEL;
                        spi_cs_n  <= 1'b1;
                        desel_cnt <= DESEL_LAST;
`endif
                    end
                end
                STREAM: begin
`ifdef BIOS_SPI_ROM_PREFETCH_EN
                    if (eng_busy && miss) stream_miss <= 1'b1;
                    if (eng_done) begin
                        if (stream_miss || miss) begin
                            state     <= DESEL;
                            spi_cs_n  <= 1'b1;
                            desel_cnt <= DESEL_LAST;
                        end else begin
                            pf_data <= byte_swap(eng_rx);
                            pf_vld  <= 1'b1;
                        end
                    end else if (stream_hit) begin
                        buf_data    <= pf_data;
                        buf_addr    <= pf_tag;
                        buf_vld     <= 1'b1;
                        pf_vld      <= 1'b0;
                        stream_miss <= 1'b0;
                        if (pf_tag != 14'h3FFF) begin
                            pf_tag <= pf_tag + 14'd1;
                        end else begin
                            state     <= DESEL;
                            spi_cs_n  <= 1'b1;
                            desel_cnt <= DESEL_LAST;
                        end
                    end else if (pf_vld && miss) begin
                        pf_vld    <= 1'b0;
                        state     <= DESEL;
                        spi_cs_n  <= 1'b1;
                        desel_cnt <= DESEL_LAST;
                    end
`else
                    state <= IDLE;
`endif
                end
                DESEL: begin
                    if (desel_cnt == '0) state <= IDLE;
                    else desel_cnt <= desel_cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bios_spi_rom.sv
// Directed bench for bios_spi_rom with a small SPI flash model; covers the BIOS_SPI_ROM_PREFETCH_EN build too.
module tb_bios_spi_rom;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] rom_address = '0;
    logic        rom_rd_enable = 1'b0;
    logic        rom_rd_enable2 = 1'b0;
    logic [31:0] rom_rd_data, rom_rd_data2;
    logic        rom_rd_valid, rom_rd_valid2;
    logic        spi_cs_n, spi_sck, spi_mosi;
    logic        spi_cs_n2, spi_sck2, spi_mosi2;
    logic        spi_miso = 1'b0;
    logic        spi_miso2 = 1'b0;

    int vectors = 0;
    int errors  = 0;

    bios_spi_rom #(.FLASH_BASE(24'h000000), .CLK_DIV(1), .CS_HIGH(2)) dut (
        .clk(clk), .rst(rst), .rom_address(rom_address), .rom_rd_enable(rom_rd_enable),
        .rom_rd_data(rom_rd_data), .rom_rd_valid(rom_rd_valid),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    bios_spi_rom #(.FLASH_BASE(24'hFFFFFC), .CLK_DIV(1), .CS_HIGH(2)) dut_wrap (
        .clk(clk), .rst(rst), .rom_address(rom_address), .rom_rd_enable(rom_rd_enable2),
        .rom_rd_data(rom_rd_data2), .rom_rd_valid(rom_rd_valid2),
        .spi_cs_n(spi_cs_n2), .spi_sck(spi_sck2), .spi_mosi(spi_mosi2), .spi_miso(spi_miso2)
    );

    always #10 clk = ~clk;

    // Flash model: every word read returns bytes 11 22 33 44 in order.
    logic [31:0] flash_word = 32'h11223344;
    logic [63:0] rx_frame = '0;
    int          rx_bits = 0;
    int          frames = 0;
    logic        sck_q = 1'b0;
    logic        cs_q = 1'b1;
    logic [63:0] rx2_frame = '0;
    logic        sck2_q = 1'b0;

    always @(negedge clk) begin
        if (!spi_cs_n && cs_q) frames++;
        if (spi_cs_n) begin
            rx_bits = 0;
        end else begin
            if (spi_sck && !sck_q) begin
                rx_frame = {rx_frame[62:0], spi_mosi};
                rx_bits++;
            end
            if (!spi_sck && sck_q && rx_bits >= 32)
                spi_miso = flash_word[31 - ((rx_bits - 32) % 32)];
        end
        sck_q = spi_sck;
        cs_q  = spi_cs_n;
        if (!spi_cs_n2 && spi_sck2 && !sck2_q) rx2_frame = {rx2_frame[62:0], spi_mosi2};
        sck2_q = spi_sck2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        vectors++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
        vectors++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rom_rd_valid); end
        vectors++; if (rom_rd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 00000000", rom_rd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_first_read();
        int f0;
        f0 = frames;
        rom_address   = 14'd0;
        rom_rd_enable = 1'b1;
        #1;
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL first_valid_N: got %b want 0", rom_rd_valid); end
        vectors++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL first_cs_N: got %b want 1", spi_cs_n); end
        tick();
        vectors++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL first_cs_N1: got %b want 0", spi_cs_n); end
        repeat (128) tick();
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL first_valid_N129: got %b want 0", rom_rd_valid); end
        tick();
        vectors++; if (rom_rd_valid !== 1'b1) begin errors++; $display("FAIL first_valid_N130: got %b want 1", rom_rd_valid); end
        vectors++; if (rom_rd_data !== 32'h44332211) begin errors++; $display("FAIL first_data: got %h want 44332211", rom_rd_data); end
        vectors++; if (rx_frame[63:32] !== 32'h03000000) begin errors++; $display("FAIL first_mosi: got %h want 03000000", rx_frame[63:32]); end
        vectors++; if (frames !== f0 + 1) begin errors++; $display("FAIL first_frames: got %0d want %0d", frames, f0 + 1); end
    endtask

    task automatic test_hit();
        int f0;
        f0 = frames;
        rom_rd_enable = 1'b0;
        #1;
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL hit_gated: got %b want 0", rom_rd_valid); end
        tick();
        rom_rd_enable = 1'b1;
        #1;
        vectors++; if (rom_rd_valid !== 1'b1) begin errors++; $display("FAIL hit_same_cycle: got %b want 1", rom_rd_valid); end
        vectors++; if (rom_rd_data !== 32'h44332211) begin errors++; $display("FAIL hit_data: got %h want 44332211", rom_rd_data); end
        repeat (10) tick();
        vectors++; if (frames !== f0) begin errors++; $display("FAIL hit_no_frame: got %0d want %0d", frames, f0); end
    endtask

    task automatic test_wrap();
        rom_rd_enable  = 1'b0;
        rom_address    = 14'h0001;
        rom_rd_enable2 = 1'b1;
        repeat (130) tick();
        vectors++; if (rom_rd_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b want 1", rom_rd_valid2); end
        vectors++; if (rx2_frame[63:32] !== 32'h03000000) begin errors++; $display("FAIL wrap_mosi: got %h want 03000000", rx2_frame[63:32]); end
        vectors++; if (rom_rd_data2 !== 32'h0) begin errors++; $display("FAIL wrap_data: got %h want 00000000", rom_rd_data2); end
        rom_rd_enable2 = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_addr_change();
        int  hi;
        bit  seen;
        rom_address   = 14'd5;
        rom_rd_enable = 1'b1;
        repeat (40) tick();
        rom_address = 14'd9;
        repeat (90) tick();
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL chg_valid_old: got %b want 0", rom_rd_valid); end
        vectors++; if (rx_frame[63:32] !== 32'h03000014) begin errors++; $display("FAIL chg_mosi_first: got %h want 03000014", rx_frame[63:32]); end
        hi   = spi_cs_n ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (spi_cs_n) hi++;
            else if (hi > 0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b1) begin errors++; $display("FAIL chg_second_frame: got %b want 1 (timeout)", seen); end
        vectors++; if (hi < 3) begin errors++; $display("FAIL chg_cs_gap: got %0d want >=3", hi); end
        repeat (128) tick();
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL chg_valid_early: got %b want 0", rom_rd_valid); end
        tick();
        vectors++; if (rom_rd_valid !== 1'b1) begin errors++; $display("FAIL chg_valid_new: got %b want 1", rom_rd_valid); end
        vectors++; if (rx_frame[63:32] !== 32'h03000024) begin errors++; $display("FAIL chg_mosi_second: got %h want 03000024", rx_frame[63:32]); end
        vectors++; if (rom_rd_data !== 32'h44332211) begin errors++; $display("FAIL chg_data: got %h want 44332211", rom_rd_data); end
    endtask

    task automatic test_reset_mid();
        int f0;
        rom_address = 14'd2;
        repeat (60) tick();
        vectors++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL rmid_in_frame: got %b want 0", spi_cs_n); end
        rst = 1'b1;
        #1;
        vectors++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL rmid_cs_n: got %b want 1", spi_cs_n); end
        vectors++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL rmid_sck: got %b want 0", spi_sck); end
        vectors++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL rmid_mosi: got %b want 0", spi_mosi); end
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", rom_rd_valid); end
        vectors++; if (rom_rd_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h want 00000000", rom_rd_data); end
        rom_rd_enable = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        f0 = frames;
        rom_rd_enable = 1'b1;
        tick();
        vectors++; if (spi_cs_n !== 1'b0) begin errors++; $display("FAIL rmid_restart_cs: got %b want 0", spi_cs_n); end
        repeat (129) tick();
        vectors++; if (rom_rd_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid_after: got %b want 1", rom_rd_valid); end
        vectors++; if (rx_frame[63:32] !== 32'h03000008) begin errors++; $display("FAIL rmid_mosi: got %h want 03000008", rx_frame[63:32]); end
        vectors++; if (frames !== f0 + 1) begin errors++; $display("FAIL rmid_frames: got %0d want %0d", frames, f0 + 1); end
    endtask

`ifdef BIOS_SPI_ROM_PREFETCH_EN
    task automatic test_prefetch();
        int f0;
        rom_rd_enable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rom_address   = 14'd0;
        rom_rd_enable = 1'b1;
        repeat (130) tick();
        vectors++; if (rom_rd_valid !== 1'b1) begin errors++; $display("FAIL pf_first_valid: got %b want 1", rom_rd_valid); end
        repeat (70) tick();
        f0 = frames;
        rom_address = 14'd1;
        #1;
        vectors++; if (rom_rd_valid !== 1'b0) begin errors++; $display("FAIL pf_valid_miss: got %b want 0", rom_rd_valid); end
        tick();
        vectors++; if (rom_rd_valid !== 1'b1) begin errors++; $display("FAIL pf_valid_next: got %b want 1", rom_rd_valid); end
        vectors++; if (rom_rd_data !== 32'h44332211) begin errors++; $display("FAIL pf_data: got %h want 44332211", rom_rd_data); end
        vectors++; if (frames !== f0) begin errors++; $display("FAIL pf_no_opcode: got %0d want %0d", frames, f0); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_read();
        test_hit();
        test_wrap();
        test_addr_change();
        test_reset_mid();
`ifdef BIOS_SPI_ROM_PREFETCH_EN
        test_prefetch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
